// File: rtl/seq_controller.sv
// Programmable step sequencer driving data_path sel1/sel2, advanced by ce ticks on clk.
// Optional repeat mode is compiled in with SEQ_CTRL_LOOP_EN.
module seq_controller #(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned DWELL_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [5:0]         wr_sel1,
    input  logic               wr_sel2,
    input  logic [DWELL_W-1:0] wr_dwell,
    output logic [5:0]         sel1,
    output logic               sel2,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   step_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_STEPS - 1);

    logic [5:0]         tbl_sel1  [NUM_STEPS];
    logic               tbl_sel2  [NUM_STEPS];
    logic [DWELL_W-1:0] tbl_dwell [NUM_STEPS];

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   step_idx_q, step_idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [5:0]         sel1_q, sel1_d;
    logic               sel2_q, sel2_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               loop_q, loop_d;
    logic               load_en;
    logic [IDX_W-1:0]   load_idx;

`ifndef SEQ_CTRL_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Table storage is intentionally not reset; writable only while idle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && wr_en) begin
            tbl_sel1[wr_addr]  <= wr_sel1;
            tbl_sel2[wr_addr]  <= wr_sel2;
            tbl_dwell[wr_addr] <= wr_dwell;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        cnt_d      = cnt_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        last_d     = last_q;
        loop_d     = loop_q;
        load_en    = 1'b0;
        load_idx   = '0;
        case (state_q)
            S_IDLE: begin
                sel1_d = '0;
                sel2_d = 1'b0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    load_en = 1'b1;
                    last_d  = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
`ifdef SEQ_CTRL_LOOP_EN
                    loop_d  = loop;
`else
                    loop_d  = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    sel1_d  = '0;
                    sel2_d  = 1'b0;
                end else if (ce) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (step_idx_q < last_q) begin
                        load_en  = 1'b1;
                        load_idx = step_idx_q + IDX_W'(1);
                    end else if (loop_q) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        sel1_d  = '0;
                        sel2_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Entry point for both sequence start and step advance/wrap.
        if (load_en) begin
            step_idx_d = load_idx;
            sel1_d     = tbl_sel1[load_idx];
            sel2_d     = tbl_sel2[load_idx];
            cnt_d      = tbl_dwell[load_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_idx_q <= '0;
            cnt_q      <= '0;
            sel1_q     <= '0;
            sel2_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            cnt_q      <= cnt_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            last_q     <= last_d;
            loop_q     <= loop_d;
        end
    end

    assign sel1     = sel1_q;
    assign sel2     = sel2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: randomized stimulus against a tick-counting reference model.
module tb_seq_controller;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int DW = 8;
`ifdef SEQ_CTRL_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ce, start, stop, loop, wr_en, wr_sel2;
    logic [IW-1:0] last_idx, wr_addr;
    logic [5:0]    wr_sel1;
    logic [DW-1:0] wr_dwell;
    logic [5:0]    sel1;
    logic          sel2, busy, done;
    logic [IW-1:0] step_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    // Reference model: a sequence is a walk over table entries, each lasting dwell+1 ticks.
    bit         m_run, m_done, m_loop;
    int         m_step, m_left, m_last;
    logic [5:0] m_sel1;
    logic       m_sel2;
    logic [5:0] t_sel1 [N];
    logic       t_sel2 [N];
    int         t_dwell[N];

    seq_controller #(.NUM_STEPS(N), .IDX_W(IW), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .stop(stop), .loop(loop),
        .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel1(wr_sel1),
        .wr_sel2(wr_sel2), .wr_dwell(wr_dwell), .sel1(sel1), .sel2(sel2),
        .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic model_enter(input int idx);
        m_step = idx;
        m_left = t_dwell[idx] + 1;
        m_sel1 = t_sel1[idx];
        m_sel2 = t_sel2[idx];
    endtask

    task automatic cyc();
        if (rst) begin
            m_run = 0; m_done = 0; m_step = 0; m_sel1 = '0; m_sel2 = 1'b0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (start && !stop) begin
                m_run  = 1;
                m_last = int'(last_idx);
                m_loop = LOOP_EN && loop;
                model_enter(0);
            end
            if (wr_en) begin
                t_sel1[wr_addr]  = wr_sel1;
                t_sel2[wr_addr]  = wr_sel2;
                t_dwell[wr_addr] = int'(wr_dwell);
            end
        end else if (stop) begin
            m_run = 0; m_sel1 = '0; m_sel2 = 1'b0;
        end else if (ce) begin
            m_left--;
            if (m_left == 0) begin
                if (m_step < m_last) model_enter(m_step + 1);
                else if (m_loop) model_enter(0);
                else begin
                    m_run = 0; m_done = 1; m_sel1 = '0; m_sel2 = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle_inputs();
        ce = 0; start = 0; stop = 0; loop = 0; wr_en = 0;
        wr_addr = '0; wr_sel1 = '0; wr_sel2 = 0; wr_dwell = '0;
    endtask

    task automatic wr(input int a, input logic [5:0] s1, input logic s2, input int dw);
        wr_en = 1; wr_addr = IW'(a); wr_sel1 = s1; wr_sel2 = s2; wr_dwell = DW'(dw);
        cyc();
        wr_en = 0;
    endtask

    task automatic load_basic();
        wr(0, 6'h05, 1'b1, 0);
        wr(1, 6'h2A, 1'b0, 2);
        wr(2, 6'h3F, 1'b1, 1);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; cyc(); cyc();
        n_checks++;
        if ({sel1, sel2, busy, done, step_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_init got sel1=%h sel2=%b busy=%b done=%b idx=%0d want all zero", sel1, sel2, busy, done, step_idx);
        end
        rst = 0;
        load_basic();
        last_idx = 3'd2; start = 1; cyc(); start = 0;
        ce = 1; cyc(); cyc();
        rst = 1; cyc(); cyc();
        rst = 0; ce = 0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== '0) begin
                n_fail++;
                $display("FAIL reset_midrun got sel1=%h sel2=%b busy=%b done=%b idx=%0d want all zero", sel1, sel2, busy, done, step_idx);
            end
            cyc();
        end
    endtask

    task automatic test_basic();
        logic [5:0] seen[$];
        logic [5:0] want[6];
        int dones = 0;
        want[0] = 6'h05; want[1] = 6'h2A; want[2] = 6'h2A;
        want[3] = 6'h2A; want[4] = 6'h3F; want[5] = 6'h3F;
        idle_inputs();
        load_basic();
        last_idx = 3'd2; start = 1;
        for (int i = 0; i < 40; i++) begin
            ce = (i % 4 == 3);
            if (busy && ce) seen.push_back(sel1);
            cyc();
            start = 0;
            if (done) dones++;
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== {m_sel1, m_sel2, m_run, m_done, IW'(m_step)}) begin
                n_fail++;
                $display("FAIL basic_cycle got sel1=%h sel2=%b busy=%b done=%b idx=%0d want %h %b %b %b %0d",
                         sel1, sel2, busy, done, step_idx, m_sel1, m_sel2, m_run, m_done, m_step);
            end
        end
        n_checks++;
        if (seen.size() != 6) begin
            n_fail++;
            $display("FAIL basic_ticks got %0d ticks want 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL basic_seq tick %0d got sel1=%h want %h", i, seen[i], want[i]);
                end
            end
        end
        n_checks++;
        if (dones != 1 || sel1 !== 6'h00) begin
            n_fail++;
            $display("FAIL basic_done got dones=%0d sel1=%h want 1 and 00", dones, sel1);
        end
    endtask

    task automatic test_stop();
        bit hit = 0;
        idle_inputs();
        load_basic();
        last_idx = 3'd2; start = 1; cyc(); start = 0;
        ce = 1;
        for (int i = 0; i < 20 && !hit; i++) begin
            stop = (busy && step_idx == 3'd1 && m_left == 1);
            hit = stop;
            cyc();
        end
        stop = 0; ce = 0;
        n_checks++;
        if (!hit || {sel1, busy, done, step_idx} !== {6'h00, 1'b0, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL stop_final_tick hit=%0d got sel1=%h busy=%b done=%b idx=%0d want 00 0 0 1", hit, sel1, busy, done, step_idx);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_no_done got busy=%b done=%b want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_write_protect();
        bit saw11 = 0, got_done = 0;
        int max_idx = 0, dones = 0;
        logic [5:0] step1_val = '0;
        idle_inputs();
        load_basic();
        last_idx = 3'd2; start = 1;
        for (int i = 0; i < 200 && !got_done; i++) begin
            ce = 1'($urandom_range(0, 1));
            wr_en = (i == 3); wr_addr = 3'd1; wr_sel1 = 6'h11; wr_dwell = '0;
            cyc();
            start = 0; wr_en = 0;
            if (sel1 === 6'h11) saw11 = 1;
            got_done = done;
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== {m_sel1, m_sel2, m_run, m_done, IW'(m_step)}) begin
                n_fail++;
                $display("FAIL wp_cycle got sel1=%h busy=%b done=%b idx=%0d want %h %b %b %0d", sel1, busy, done, step_idx, m_sel1, m_run, m_done, m_step);
            end
        end
        n_checks++;
        if (saw11 || !got_done) begin
            n_fail++;
            $display("FAIL wp_run got saw11=%0d done=%0d want 0 1", saw11, got_done);
        end
        ce = 0; cyc();
        last_idx = 3'd1; start = 1; cyc(); start = 0; ce = 1;
        for (int i = 0; i < 6; i++) begin
            if (busy && step_idx == 3'd1) step1_val = sel1;
            cyc();
        end
        n_checks++;
        if (step1_val !== 6'h2A) begin
            n_fail++;
            $display("FAIL wp_entry_kept got sel1=%h want 2a", step1_val);
        end
        ce = 0; cyc();
        for (int a = 0; a < N; a++) wr(a, 6'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        last_idx = 3'd7; start = 1; got_done = 0;
        for (int i = 0; i < 300 && !got_done; i++) begin
            ce = 1'($urandom_range(0, 1));
            cyc();
            start = 0;
            if (busy && int'(step_idx) > max_idx) max_idx = int'(step_idx);
            if (done) dones++;
            got_done = done;
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== {m_sel1, m_sel2, m_run, m_done, IW'(m_step)}) begin
                n_fail++;
                $display("FAIL full_cycle got sel1=%h busy=%b done=%b idx=%0d want %h %b %b %0d", sel1, busy, done, step_idx, m_sel1, m_run, m_done, m_step);
            end
        end
        n_checks++;
        if (max_idx != 7 || dones != 1) begin
            n_fail++;
            $display("FAIL full_table got max_idx=%0d dones=%0d want 7 1", max_idx, dones);
        end
        ce = 0; cyc(); cyc();
    endtask

    task automatic test_collision();
        idle_inputs();
        start = 1; stop = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL collision got busy=%b done=%b want 0 0", busy, done);
            end
        end
        idle_inputs(); cyc();
    endtask

    task automatic test_loop();
        int ticks = 0, dones = 0;
        idle_inputs();
        wr(0, 6'h0A, 1'b0, 0);
        wr(1, 6'h15, 1'b1, 0);
        last_idx = 3'd1; loop = 1; start = 1; cyc(); start = 0; loop = 0;
        for (int i = 0; i < 20 && ticks < 10; i++) begin
            ce = 1'($urandom_range(0, 1));
            if (ce && (busy || done)) ticks++;
            cyc();
            if (done) dones++;
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== {m_sel1, m_sel2, m_run, m_done, IW'(m_step)}) begin
                n_fail++;
                $display("FAIL loop_cycle got sel1=%h busy=%b done=%b idx=%0d want %h %b %b %0d", sel1, busy, done, step_idx, m_sel1, m_run, m_done, m_step);
            end
        end
        n_checks++;
        if (dones != (LOOP_EN ? 0 : 1)) begin
            n_fail++;
            $display("FAIL loop_dones got %0d want %0d", dones, LOOP_EN ? 0 : 1);
        end
        ce = 0; stop = 1; cyc(); stop = 0; cyc();
        n_checks++;
        if (busy !== 1'b0 || sel1 !== 6'h00) begin
            n_fail++;
            $display("FAIL loop_stop got busy=%b sel1=%h want 0 00", busy, sel1);
        end
    endtask

    task automatic test_back_to_back();
        int last_done = -1, gaps = 0;
        idle_inputs();
        wr(0, 6'h33, 1'b1, 0);
        last_idx = 3'd0; start = 1; ce = 1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (done) last_done = i;
            if (busy && last_done >= 0) begin
                gaps++;
                n_checks++;
                if (i - last_done != 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap got %0d cycles done->busy want 2", i - last_done);
                end
                last_done = -1;
            end
            n_checks++;
            if ({sel1, sel2, busy, done, step_idx} !== {m_sel1, m_sel2, m_run, m_done, IW'(m_step)}) begin
                n_fail++;
                $display("FAIL b2b_cycle got sel1=%h busy=%b done=%b idx=%0d want %h %b %b %0d", sel1, busy, done, step_idx, m_sel1, m_run, m_done, m_step);
            end
        end
        n_checks++;
        if (gaps < 5) begin
            n_fail++;
            $display("FAIL b2b_restarts got %0d want >=5", gaps);
        end
        idle_inputs(); cyc();
    endtask

    initial begin
        m_sel1 = '0; m_sel2 = 1'b0; m_step = 0; m_left = 0; m_last = 0;
        rst = 1; last_idx = '0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stop();
        test_write_protect();
        test_collision();
        test_loop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
